// File: rtl/serial_addsub_unit.sv
// -----------------------------------------------------------------------------
// serial_addsub_unit
//   Multi-cycle adder/subtractor. Each clock pushes DIGIT bits through a ripple
//   full-adder slice, and the carry is held in a register between clocks.
//   An operation takes N = WIDTH/DIGIT clocks. It is controlled by a
//   start/busy/done handshake and produces the sum, an unsigned carry/borrow
//   flag and a signed overflow flag.
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset
//   start in   1      operation request, sampled only when not busy
//   sub   in   1      0: a+b, 1: a-b (sampled with start)
//   a     in   WIDTH  operand A (sampled with start)
//   b     in   WIDTH  operand B (sampled with start)
//   busy  out  1      high while the operation is running
//   done  out  1      one-cycle pulse; sum/cout/ovf are valid from this cycle
//   sum   out  WIDTH  result, held until the next operation completes
//   cout  out  1      add: carry out; sub: 1 = no borrow (a >= b unsigned)
//   ovf   out  1      signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT-1:0] dsum_s;
  logic [DIGIT:0]   chain_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  // One-bit full adder; the result is {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple slice over the low DIGIT bits of the operand shift registers.
  always_comb begin
    chain_s    = '0;
    dsum_s     = '0;
    chain_s[0] = carry_r;
    for (int i = 0; i < DIGIT; i++) begin
      {chain_s[i+1], dsum_s[i]} = full_add(a_r[i], b_r[i], chain_s[i]);
    end
    // New digit enters at the MSB end; after N steps digit 0 has reached bit 0.
    res_next_s = (res_r >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));
    if (state_r == RUN && cnt_r == CW'(N - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            res_r   <= '0;
            cnt_r   <= '0;
            state_r <= RUN;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= chain_s[DIGIT];
          res_r   <= res_next_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            // Bit WIDTH-1 is the top bit of the last digit, so its carry-in
            // is chain_s[DIGIT-1] and its carry-out is chain_s[DIGIT].
            sum     <= res_next_s;
            cout    <= chain_s[DIGIT];
            ovf     <= chain_s[DIGIT] ^ chain_s[DIGIT-1];
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            // Back-to-back accept: no idle cycle between operations.
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            res_r   <= '0;
            cnt_r   <= '0;
            state_r <= RUN;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_unit
//   Directed bench for serial_addsub_unit. It drives a bit-serial instance
//   (WIDTH=8, DIGIT=1) and a nibble-serial instance (WIDTH=8, DIGIT=4).
//   Expected results come from a reference arithmetic model. They are queued
//   when an operation starts and compared when the matching done pulse arrives.
// -----------------------------------------------------------------------------
module tb_serial_addsub_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, sub1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, sum1;
  logic       start4, sub4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, sum4;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   total  = 0;
  int   passes = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_addsub_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Reference model: an unsigned 9-bit sum, with signed overflow taken from the operand/result signs.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [7:0] bb;
    logic [8:0] f;
    exp_t       m;
    bb  = b ^ {8{sub}};
    f   = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    m.s = f[7:0];
    m.c = f[8];
    m.o = (a[7] == bb[7]) && (f[7] != a[7]);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse and queue its expected result.
  task automatic do_start(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic sub);
    if (sel) begin
      a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
      q4.push_back(model(a, b, sub));
    end else begin
      a1 = a; b1 = b; sub1 = sub; start1 = 1'b1;
      q1.push_back(model(a, b, sub));
    end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency, busy length and the queued result.
  task automatic wait_result(input bit sel, input string tag, input int exp_lat);
    int   n;
    int   bz;
    exp_t e;
    n  = 0;
    bz = 0;
    while (!(sel ? done4 : done1) && n < exp_lat + 4) begin
      if (sel ? busy4 : busy1) bz++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(bz), 32'(exp_lat));
    if (sel) begin
      check({tag, " queue"}, 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check({tag, " sum"}, 32'(sum4), 32'(e.s));
        check({tag, " cout"}, 32'(cout4), 32'(e.c));
        check({tag, " ovf"}, 32'(ovf4), 32'(e.o));
      end
    end else begin
      check({tag, " queue"}, 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check({tag, " sum"}, 32'(sum1), 32'(e.s));
        check({tag, " cout"}, 32'(cout1), 32'(e.c));
        check({tag, " ovf"}, 32'(ovf1), 32'(e.o));
      end
    end
  endtask

  initial begin
    int dn;
    rst = 1'b1;
    start1 = 1'b0; sub1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    start4 = 1'b0; sub4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst sum", 32'(sum1), 32'd0);
    check("rst cout", 32'(cout1), 32'd0);
    check("rst ovf", 32'(ovf1), 32'd0);
    check("rst sum4", 32'(sum4), 32'd0);

    // 1: 0x5A + 0x3C, bit-serial
    do_start(1'b0, 8'h5A, 8'h3C, 1'b0);
    wait_result(1'b0, "t1", 8);
    @(negedge clk);
    check("t1 done_pulse_width", 32'(done1), 32'd0);

    // 2: carry-out wrap and signed overflow on subtract
    do_start(1'b0, 8'hFF, 8'h01, 1'b0);
    wait_result(1'b0, "t2a", 8);
    @(negedge clk);
    do_start(1'b0, 8'h80, 8'h01, 1'b1);
    wait_result(1'b0, "t2b", 8);

    // 3: subtract with borrow
    @(negedge clk);
    do_start(1'b0, 8'h10, 8'h20, 1'b1);
    wait_result(1'b0, "t3", 8);

    // 4: nibble-serial, two clocks per op
    do_start(1'b1, 8'h5A, 8'h3C, 1'b0);
    wait_result(1'b1, "t4a", 2);
    @(negedge clk);
    do_start(1'b1, 8'h80, 8'h01, 1'b1);
    wait_result(1'b1, "t4b", 2);

    // 5: start while busy is ignored; back-to-back start in the DONE cycle
    @(negedge clk);
    do_start(1'b0, 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'h00; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_result(1'b0, "t5a", 5);
    do_start(1'b0, 8'h03, 8'h04, 1'b0);
    check("t5 done_single", 32'(done1), 32'd0);
    check("t5 busy_no_gap", 32'(busy1), 32'd1);
    check("t5 sum_held", 32'(sum1), 32'h02);
    wait_result(1'b0, "t5b", 8);

    // 6: reset mid-operation aborts and clears outputs
    @(negedge clk);
    do_start(1'b0, 8'h5A, 8'h3C, 1'b0);
    wait_result(1'b0, "t6a", 8);
    @(negedge clk);
    do_start(1'b0, 8'h11, 8'h22, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    check("t6 busy", 32'(busy1), 32'd0);
    check("t6 done", 32'(done1), 32'd0);
    check("t6 sum", 32'(sum1), 32'd0);
    check("t6 cout", 32'(cout1), 32'd0);
    check("t6 ovf", 32'(ovf1), 32'd0);
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done1) dn++;
    end
    check("t6 no_done", 32'(dn), 32'd0);
    do_start(1'b0, 8'h10, 8'h20, 1'b1);
    wait_result(1'b0, "t6b", 8);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
